impulse_sequencer: RTL
======================

Name: impulse_sequencer

Overview:
- Downstream consumer of the SPI parameter receiver (51-byte frame).
- Latches the decoded parameter set on the receiver's SPI_WR strobe and keeps the 64-bit system time.
- At TIME_START it emits a burst of N_impulse transmit periods with blanking gates.
- Outputs a per-impulse stepped frequency word for the DDS/synthesizer stage.

Parameters:
- FREQ_W, 48, frequency word width (FREQ, FREQ_STEP, FREQ_OUT).
- TIME_W, 64, system time width.

Ports:
- clk  in  1  system clock, 48 MHz.
- rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  tick enable; all timers and SYS_TIME advance only when clk_en=1.
- SPI_WR  in  1  one-cycle strobe: the parameter inputs below are valid; shadow-load them.
- SYS_TIME_UPDATE  in  1  one-cycle strobe: load TIME into SYS_TIME.
- TIME  in  64  new system time value.
- FREQ  in  48  start frequency word.
- FREQ_STEP  in  48  per-impulse frequency increment.
- TIME_START  in  64  SYS_TIME value at which the burst starts.
- N_impulse  in  16  impulse count.
- TYPE_impulse  in  8  bit0 enables frequency stepping; bits 7:1 reserved and ignored.
- Interval_Ti  in  32  impulse width, in ticks.
- Interval_Tp  in  32  repetition period, in ticks.
- Tblank1  in  32  post-impulse blanking length, in ticks.
- Tblank2  in  32  end-of-period blanking length, in ticks.
- SYS_TIME  out  64  running system time.
- IMP  out  1  transmit gate.
- BLANK  out  1  receiver blanking gate.
- FREQ_OUT  out  48  frequency word for the current impulse.
- BUSY  out  1  high in ARMED or RUN.
- DONE  out  1  one-cycle pulse at burst end.
- LATE  out  1  sticky flag: TIME_START already passed at arm.

Behaviour:
- Reset: SYS_TIME=0, IMP=0, BLANK=0, FREQ_OUT=0, BUSY=0, DONE=0, LATE=0; all shadow registers 0; state IDLE.
- SYS_TIME:
  - SYS_TIME_UPDATE has priority: SYS_TIME<=TIME on that edge, independent of clk_en.
  - Otherwise SYS_TIME<=SYS_TIME+1 when clk_en=1; wraps modulo 2^64.
- SPI_WR in any state:
  - Shadow all parameters; FREQ_OUT<=FREQ; LATE<=0; IMP/BLANK forced to 0.
  - State<=ARMED, so SPI_WR during RUN aborts the burst and re-arms. No DONE on abort.
- Shadow clamping, applied at load: Tp=0 is treated as 1; Ti>Tp is clamped to Tp.
- States:
  - IDLE: outputs 0; wait for SPI_WR.
  - ARMED: BUSY=1. On a clk_en tick with SYS_TIME==TIME_START: state<=RUN, period counter pc<=0, impulse index k<=0.
    - If N_impulse=0: go to IDLE instead, with DONE pulse, no IMP.
  - RUN: BUSY=1. pc counts 0..Tp-1 on clk_en ticks.
    - Registered outputs computed from the next pc value, so IMP rises on the first edge of RUN.
    - IMP=1 for pc in [0,Ti).
    - BLANK=1 for pc in [Ti,Ti+Tblank1) or pc in [Tp-Tblank2,Tp); windows are clipped to [0,Tp).
    - On pc==Tp-1 with clk_en:
      - k<=k+1, pc<=0.
      - If TYPE_impulse[0]: FREQ_OUT<=FREQ_OUT+FREQ_STEP (48-bit wrap).
      - If k+1==N_impulse: state<=IDLE, DONE=1 for one cycle, IMP/BLANK<=0.
- SYS_TIME_UPDATE while ARMED: the comparison uses the newly loaded value from the next cycle. A jump past TIME_START never starts the burst (see optional feature).
- SYS_TIME_UPDATE during RUN: no effect on the running burst.
- SPI_WR and SYS_TIME_UPDATE in the same cycle: both take effect.
- clk_en=0: all counters and outputs hold; DONE/state changes happen only on ticks, except SPI_WR, which is honoured regardless of clk_en.

Optional Feature:
- Macro IMPULSE_LATE_START_EN.
- Defined: in ARMED, a tick with (TIME_START - SYS_TIME) interpreted as negative signed 64-bit sets LATE=1 and starts RUN immediately on that tick.
- Undefined: no late check. ARMED waits for exact equality (possibly until wrap-around) and LATE stays 0.

Test Plan:
1. Reset, then SYS_TIME_UPDATE with TIME=0x80000000000000F1, clk_en=1 -> SYS_TIME=0x80000000000000F2 one tick later; all outputs otherwise at reset values.
2. Arm with TIME_START=SYS_TIME+10, N=3, Ti=5, Tp=20, Tblank1=3, Tblank2=2, FREQ=1, FREQ_STEP=2, TYPE=1 -> IMP rises 10 ticks after arm for 5 ticks, three times, 20 ticks apart. BLANK covers ticks 5-7 and 18-19 of each period. FREQ_OUT reads 1, 3, 5. DONE pulses once at tick 60; BUSY drops.
3. Same as 2 with TYPE=0 and N=0 -> with N=0: DONE at TIME_START, IMP never asserts. With N=2, TYPE=0: FREQ_OUT stays 1.
4. Second SPI_WR at the middle of impulse 2 of scenario 2 -> IMP/BLANK drop next cycle, no DONE, BUSY stays 1, new burst starts at the new TIME_START.
5. Ti=30, Tp=20, Tp=0 variant -> IMP continuously high across the burst; Tp=0 yields 1-tick periods, N ticks total.
6. Toggle clk_en 1/0 alternately during scenario 2 -> all timings doubled in clk cycles. TIME_START already passed at arm: with IMPULSE_LATE_START_EN, LATE=1 and immediate start; without it, no start and BUSY=1.

Source files
------------

// File: rtl/impulse_sequencer.sv
// Impulse burst sequencer: shadows an SPI parameter frame, keeps system time and emits a timed
// burst of transmit/blanking gates with a stepped frequency word. Option: IMPULSE_LATE_START_EN.
module impulse_sequencer #(
   parameter int unsigned FREQ_W = 48,
   parameter int unsigned TIME_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clk_en,
   input  logic              SPI_WR,
   input  logic              SYS_TIME_UPDATE,
   input  logic [TIME_W-1:0] TIME,
   input  logic [FREQ_W-1:0] FREQ,
   input  logic [FREQ_W-1:0] FREQ_STEP,
   input  logic [TIME_W-1:0] TIME_START,
   input  logic [15:0]       N_impulse,
   input  logic [7:0]        TYPE_impulse,
   input  logic [31:0]       Interval_Ti,
   input  logic [31:0]       Interval_Tp,
   input  logic [31:0]       Tblank1,
   input  logic [31:0]       Tblank2,
   output logic [TIME_W-1:0] SYS_TIME,
   output logic              IMP,
   output logic              BLANK,
   output logic [FREQ_W-1:0] FREQ_OUT,
   output logic              BUSY,
   output logic              DONE,
   output logic              LATE
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StArmed = 2'd1;
   localparam logic [1:0] StRun   = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [TIME_W-1:0] sys_time_q, sys_time_d;
   logic [TIME_W-1:0] time_start_q, time_start_d;
   logic [FREQ_W-1:0] freq_out_q, freq_out_d;
   logic [FREQ_W-1:0] freq_step_q, freq_step_d;
   logic [15:0]       n_q, n_d;
   logic [15:0]       k_q, k_d;
   logic              step_en_q, step_en_d;
   logic [31:0]       ti_q, ti_d;
   logic [31:0]       tp_q, tp_d;
   logic [31:0]       tb1_q, tb1_d;
   logic [31:0]       tb2_q, tb2_d;
   logic [31:0]       pc_q, pc_d;
   logic              imp_q, imp_d;
   logic              blank_q, blank_d;
   logic              done_q, done_d;
   logic              late_q, late_d;

   logic [31:0]       tp_ld, ti_ld, pc_run, pc_win;
   logic              period_end, last_imp, start_hit, late_hit, imp_win, blank_win;
   logic              unused_type;

   assign unused_type = ^TYPE_impulse[7:1];

   assign tp_ld      = (Interval_Tp == 32'd0) ? 32'd1 : Interval_Tp;
   assign ti_ld      = (Interval_Ti > tp_ld) ? tp_ld : Interval_Ti;
   assign period_end = (pc_q == tp_q - 32'd1);
   assign last_imp   = (({1'b0, k_q} + 17'd1) == {1'b0, n_q});
   assign pc_run     = period_end ? 32'd0 : pc_q + 32'd1;
   // Gates are registered from the pc value being entered, so a burst start evaluates pc=0.
   assign pc_win     = (state_q == StRun) ? pc_run : 32'd0;
   assign imp_win    = (pc_win < ti_q);
   assign blank_win  = ((pc_win >= ti_q) && ({1'b0, pc_win} < ({1'b0, ti_q} + {1'b0, tb1_q})))
                     || (({1'b0, pc_win} + {1'b0, tb2_q}) >= {1'b0, tp_q});
   assign start_hit  = (sys_time_q == time_start_q);

`ifdef IMPULSE_LATE_START_EN
   logic [TIME_W-1:0] time_diff;
   assign time_diff = time_start_q - sys_time_q;
   assign late_hit  = time_diff[TIME_W-1];
`else
   assign late_hit = 1'b0;
`endif

   always_comb begin
      sys_time_d = sys_time_q;
      if (SYS_TIME_UPDATE) begin
         sys_time_d = TIME;
      end else if (clk_en) begin
         sys_time_d = sys_time_q + TIME_W'(1);
      end
   end

   always_comb begin
      state_d      = state_q;
      time_start_d = time_start_q;
      freq_out_d   = freq_out_q;
      freq_step_d  = freq_step_q;
      n_d          = n_q;
      k_d          = k_q;
      step_en_d    = step_en_q;
      ti_d         = ti_q;
      tp_d         = tp_q;
      tb1_d        = tb1_q;
      tb2_d        = tb2_q;
      pc_d         = pc_q;
      imp_d        = imp_q;
      blank_d      = blank_q;
      done_d       = 1'b0;
      late_d       = late_q;
      if (SPI_WR) begin
         time_start_d = TIME_START;
         freq_out_d   = FREQ;
         freq_step_d  = FREQ_STEP;
         n_d          = N_impulse;
         step_en_d    = TYPE_impulse[0];
         ti_d         = ti_ld;
         tp_d         = tp_ld;
         tb1_d        = Tblank1;
         tb2_d        = Tblank2;
         imp_d        = 1'b0;
         blank_d      = 1'b0;
         late_d       = 1'b0;
         state_d      = StArmed;
      end else if (clk_en) begin
         case (state_q)
            StArmed: begin
               if (start_hit || late_hit) begin
                  if (late_hit) late_d = 1'b1;
                  if (n_q == 16'd0) begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end else begin
                     state_d = StRun;
                     pc_d    = 32'd0;
                     k_d     = 16'd0;
                     imp_d   = imp_win;
                     blank_d = blank_win;
                  end
               end
            end
            StRun: begin
               pc_d    = pc_run;
               imp_d   = imp_win;
               blank_d = blank_win;
               if (period_end) begin
                  k_d = k_q + 16'd1;
                  if (step_en_q) freq_out_d = freq_out_q + freq_step_q;
                  if (last_imp) begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                     imp_d   = 1'b0;
                     blank_d = 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         sys_time_q   <= '0;
         time_start_q <= '0;
         freq_out_q   <= '0;
         freq_step_q  <= '0;
         n_q          <= '0;
         k_q          <= '0;
         step_en_q    <= 1'b0;
         ti_q         <= '0;
         tp_q         <= '0;
         tb1_q        <= '0;
         tb2_q        <= '0;
         pc_q         <= '0;
         imp_q        <= 1'b0;
         blank_q      <= 1'b0;
         done_q       <= 1'b0;
         late_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sys_time_q   <= sys_time_d;
         time_start_q <= time_start_d;
         freq_out_q   <= freq_out_d;
         freq_step_q  <= freq_step_d;
         n_q          <= n_d;
         k_q          <= k_d;
         step_en_q    <= step_en_d;
         ti_q         <= ti_d;
         tp_q         <= tp_d;
         tb1_q        <= tb1_d;
         tb2_q        <= tb2_d;
         pc_q         <= pc_d;
         imp_q        <= imp_d;
         blank_q      <= blank_d;
         done_q       <= done_d;
         late_q       <= late_d;
      end
   end

   assign SYS_TIME = sys_time_q;
   assign IMP      = imp_q;
   assign BLANK    = blank_q;
   assign FREQ_OUT = freq_out_q;
   assign BUSY     = (state_q != StIdle);
   assign DONE     = done_q;
   assign LATE     = late_q;

endmodule
